// File: rtl/xdrs_pkg.sv
// ----------------------------------------------------------------------------
// xdrs_pkg
// Items shared by the partial-reconfiguration control blocks:
//   - reconf_state_t : state encoding of reconf_sequencer
//   - DEF_RST_CYCLES : default number of cycles RR reset is held after load
//   - DEF_ACK_TIMEOUT: default number of cycles to wait for the RR acknowledge
//   - max_int()      : constant helper used to size counters
// ----------------------------------------------------------------------------
package xdrs_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_ISOLATE = 3'd2,
      ST_LOAD    = 3'd3,
      ST_RESET   = 3'd4,
      ST_RELEASE = 3'd5
   } reconf_state_t;

   localparam int DEF_RST_CYCLES  = 4;
   localparam int DEF_ACK_TIMEOUT = 1024;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reconf_sequencer.sv
// ----------------------------------------------------------------------------
// reconf_sequencer
// Runs one partial-reconfiguration cycle of a reconfigurable region (RR):
// request unload, isolate the RR outputs, stream the bitstream into the
// configuration port, hold the RR in reset, then release isolation.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a cycle (only sampled while idle)
//   bs_len       : number of 32-bit words to load, captured on accepted start
//   busy         : high in every state except idle
//   done / err   : one-cycle pulses on completion / acknowledge timeout
//   rc_reqn      : active-low unload request to the RR
//   rc_ackn      : active-low acknowledge from the RR (via isolator)
//   is_reconfn   : active-low isolation enable to the isolator
//   rr_reset     : active-high reset to the RR
//   bs_valid/bs_data/bs_ready : bitstream word stream in
//   icap_cen/icap_data        : registered configuration-port write
//   dbg_state    : current FSM state (reconf_state_t encoding)
//
// Bitstream handshake: a word transfers on every rising clock edge where
// bs_valid and bs_ready are both high. bs_ready depends only on the current
// state and remaining count (never on bs_valid), and bs_valid may be raised
// or dropped at any time without penalty.
// ----------------------------------------------------------------------------
module reconf_sequencer
   import xdrs_pkg::*;
#(
   parameter int LEN_W       = 16,
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] bs_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             rc_reqn,
   input  logic             rc_ackn,
   output logic             is_reconfn,
   output logic             rr_reset,
   input  logic             bs_valid,
   input  logic [31:0]      bs_data,
   output logic             bs_ready,
   output logic             icap_cen,
   output logic [31:0]      icap_data,
   output logic [2:0]       dbg_state
);

   // One timer serves both the acknowledge wait and the reset hold; it is
   // cleared on every state change, so it always counts cycles spent in the
   // current state.
   localparam int TMR_MAX = max_int(ACK_TIMEOUT, RST_CYCLES);
   localparam int TMR_W   = $clog2(TMR_MAX) + 1;
   localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);

   reconf_state_t    r_state;
   logic [TMR_W-1:0] r_timer;
   logic [LEN_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic             r_rc_reqn;
   logic             r_is_reconfn;
   logic             r_rr_reset;
   logic             r_icap_cen;
   logic [31:0]      r_icap_data;

   reconf_state_t    w_state_nxt;
   logic [TMR_W-1:0] w_timer_nxt;
   logic             w_bs_ready;
   logic             w_fire;
   logic             w_ack_timeout;
   logic             w_err_nxt;

   assign w_bs_ready    = (r_state == ST_LOAD) && (r_cnt != '0);
   assign w_fire        = bs_valid && w_bs_ready;
   assign w_ack_timeout = (r_timer == ACK_LAST);

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            // An acknowledge arriving on the last allowed cycle still wins.
            if (!rc_ackn) begin
               w_state_nxt = ST_ISOLATE;
            end else if (w_ack_timeout) begin
               w_state_nxt = ST_IDLE;
               w_err_nxt   = 1'b1;
            end
         end
         ST_ISOLATE: begin
            w_state_nxt = (r_cnt != '0) ? ST_LOAD : ST_RESET;
         end
         ST_LOAD: begin
            if (w_fire && (r_cnt == LEN_W'(1))) w_state_nxt = ST_RESET;
         end
         ST_RESET: begin
            if (r_timer == RST_LAST) w_state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_timer_nxt = '0;
      if ((w_state_nxt == r_state) &&
          ((r_state == ST_REQ) || (r_state == ST_RESET))) begin
         w_timer_nxt = r_timer + TMR_W'(1);
      end
   end

   // State, counters and registered outputs. Outputs are decoded from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_rc_reqn    <= 1'b1;
         r_is_reconfn <= 1'b1;
         r_rr_reset   <= 1'b0;
         r_icap_cen   <= 1'b1;
         r_icap_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;

         if ((r_state == ST_IDLE) && start) begin
            r_cnt <= bs_len;
         end else if (w_fire) begin
            r_cnt <= r_cnt - LEN_W'(1);
         end

         r_icap_cen <= !w_fire;
         if (w_fire) r_icap_data <= bs_data;

         r_busy       <= (w_state_nxt != ST_IDLE);
         r_done       <= (w_state_nxt == ST_RELEASE);
         r_err        <= w_err_nxt;
         r_rc_reqn    <= (w_state_nxt != ST_REQ);
         r_is_reconfn <= !((w_state_nxt == ST_ISOLATE) ||
                           (w_state_nxt == ST_LOAD)    ||
                           (w_state_nxt == ST_RESET));
         r_rr_reset   <= (w_state_nxt == ST_RESET);
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign rc_reqn    = r_rc_reqn;
   assign is_reconfn = r_is_reconfn;
   assign rr_reset   = r_rr_reset;
   assign bs_ready   = w_bs_ready;
   assign icap_cen   = r_icap_cen;
   assign icap_data  = r_icap_data;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_reconf_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reconf_sequencer
// Bench for reconf_sequencer. The expected behaviour of each sequence is
// derived as a timeline: cycle 1 is the first cycle after the accepted start,
// REQ lasts until the RR acknowledge (or the timeout), then one isolate
// cycle, load cycles until all words are taken, RST_CYCLES reset cycles, one
// release cycle, then idle.
// ----------------------------------------------------------------------------
module tb_reconf_sequencer;
  import xdrs_pkg::*;

  localparam int LEN_W = 16;
  localparam int R     = 4;
  localparam int T     = 8;
  localparam int MAX_C = 400;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] bs_len;
  logic             busy, done, err, rc_reqn, is_reconfn, rr_reset;
  logic             rc_ackn;
  logic             bs_valid;
  logic [31:0]      bs_data;
  logic             bs_ready, icap_cen;
  logic [31:0]      icap_data;
  logic [2:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_icap;
  logic [31:0] exp_q[$];

  reconf_sequencer #(
    .LEN_W(LEN_W), .RST_CYCLES(R), .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bs_len(bs_len),
    .busy(busy), .done(done), .err(err), .rc_reqn(rc_reqn),
    .rc_ackn(rc_ackn), .is_reconfn(is_reconfn), .rr_reset(rr_reset),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
    .icap_cen(icap_cen), .icap_data(icap_data), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Control vector order: busy done err rc_reqn is_reconfn rr_reset bs_ready icap_cen
  localparam logic [7:0] IDLE_CTRL = 8'b0001_1001;

  // Driver + timeline model for one sequence, entered and left at a negedge
  // with the DUT idle. ack_d==0 means the RR never acknowledges.
  task automatic run_seq(input string name, input int len, input int ack_d,
                         input int vmode, input logic [31:0] pat,
                         input int busy_start_c, input int abort_words,
                         output int n_done, output int n_err, output int n_cen);
    int c, acc, rst_start, rel, req_end, load_start, pi;
    bit timed_out, acc_prev, finished;
    logic e_busy, e_done, e_err, e_reqn, e_isr, e_rr, e_rdy, e_cen, v;
    logic [7:0] e_ctrl, o_ctrl;
    logic [31:0] e_data, d;
    n_done = 0; n_err = 0; n_cen = 0;
    timed_out  = (ack_d == 0) || (ack_d > T);
    req_end    = timed_out ? T : ack_d;
    load_start = ack_d + 2;
    rst_start  = (!timed_out && len == 0) ? ack_d + 2 : -1;
    acc = 0; acc_prev = 0; finished = 0;
    start = 1'b1; bs_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    for (c = 1; c <= MAX_C; c++) begin
      if (timed_out) begin
        e_busy = (c <= T); e_done = 0; e_err = (c == T + 1);
        e_reqn = !(c <= T); e_isr = 1; e_rr = 0; e_rdy = 0;
      end else begin
        rel    = (rst_start >= 0) ? rst_start + R : 32'h3fff_ffff;
        e_busy = (c <= rel); e_done = (c == rel); e_err = 0;
        e_reqn = !(c <= req_end);
        e_isr  = !((c > req_end) && (c < rel));
        e_rr   = (rst_start >= 0) && (c >= rst_start) && (c < rel);
        e_rdy  = (c >= load_start) && (rst_start < 0);
      end
      e_cen  = !acc_prev;
      e_data = acc_prev ? exp_q.pop_front() : last_icap;
      if (acc_prev) last_icap = e_data;
      e_ctrl = {e_busy, e_done, e_err, e_reqn, e_isr, e_rr, e_rdy, e_cen};
      o_ctrl = {busy, done, err, rc_reqn, is_reconfn, rr_reset, bs_ready, icap_cen};
      n_done += int'(done); n_err += int'(err); n_cen += int'(!icap_cen);
      checks++;
      if (o_ctrl !== e_ctrl) begin
        errors++;
        $display("FAIL %s ctrl cycle %0d: got %b expected %b", name, c, o_ctrl, e_ctrl);
      end
      checks++;
      if (icap_data !== e_data) begin
        errors++;
        $display("FAIL %s icap_data cycle %0d: got %h expected %h", name, c, icap_data, e_data);
      end
      if (!e_busy) begin
        finished = 1;
        break;
      end
      if (abort_words >= 0 && e_rdy && acc == abort_words) begin
        rst = 1'b1; bs_valid = 1'b1; bs_data = $urandom;
        @(negedge clk);
        rst = 1'b0;
        o_ctrl = {busy, done, err, rc_reqn, is_reconfn, rr_reset, bs_ready, icap_cen};
        checks++;
        if (o_ctrl !== IDLE_CTRL || icap_data !== 32'h0) begin
          errors++;
          $display("FAIL %s abort: got ctrl %b data %h expected ctrl %b data 0",
                   name, o_ctrl, icap_data, IDLE_CTRL);
        end
        last_icap = 32'h0;
        exp_q.delete();
        finished = 1;
        break;
      end
      // drive inputs for the edge closing cycle c
      pi = c - load_start;
      if (vmode == 0) v = 1'b1;
      else if (vmode == 2 && e_rdy && pi < 32) v = pat[pi];
      else v = 1'($urandom_range(0, 1));
      d = $urandom;
      bs_valid = v; bs_data = d;
      rc_ackn = !(!timed_out && c == ack_d);
      start = (c == busy_start_c);
      bs_len = LEN_W'($urandom_range(1, 9));
      acc_prev = e_rdy && v;
      if (acc_prev) begin
        exp_q.push_back(d);
        acc++;
        if (acc == len) rst_start = c + 1;
      end
      @(negedge clk);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s cycle budget: got no end after %0d cycles expected end", name, MAX_C);
    end
    start = 1'b0; bs_valid = 1'b0; rc_ackn = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bs_len = '0; rc_ackn = 1'b1;
    bs_valid = 1'b0; bs_data = '0;
    last_icap = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, rc_reqn, is_reconfn, rr_reset, bs_ready, icap_cen} !== IDLE_CTRL ||
        icap_data !== 32'h0 || dbg_state !== 3'(ST_IDLE)) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b err=%b reqn=%b isr=%b rr=%b rdy=%b cen=%b data=%h st=%0d expected idle values",
               busy, done, err, rc_reqn, is_reconfn, rr_reset, bs_ready, icap_cen, icap_data, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, rc_reqn, is_reconfn, rr_reset, bs_ready, icap_cen} !== IDLE_CTRL) begin
      errors++;
      $display("FAIL reset_release: got busy=%b reqn=%b isr=%b expected idle", busy, rc_reqn, is_reconfn);
    end
  endtask

  task automatic test_nominal();
    int nd, ne, nc;
    run_seq("nominal", 3, 2, 0, 32'h0, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 1 || ne != 0 || nc != 3) begin
      errors++;
      $display("FAIL nominal counts: got done=%0d err=%0d cen_low=%0d expected 1 0 3", nd, ne, nc);
    end
  endtask

  task automatic test_timeout();
    int nd, ne, nc;
    run_seq("timeout", 3, 0, 1, 32'h0, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 0 || ne != 1 || nc != 0) begin
      errors++;
      $display("FAIL timeout counts: got done=%0d err=%0d cen_low=%0d expected 0 1 0", nd, ne, nc);
    end
    // acknowledge on the last allowed REQ cycle must win over the timeout
    run_seq("ack_at_limit", 2, T, 0, 32'h0, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 1 || ne != 0) begin
      errors++;
      $display("FAIL ack_at_limit counts: got done=%0d err=%0d expected 1 0", nd, ne);
    end
  endtask

  task automatic test_stalled();
    int nd, ne, nc;
    // valid pattern 1,0,0,1,1,0,1 from the first load cycle
    run_seq("stalled", 4, 3, 2, 32'h0000_0059, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 1 || nc != 4) begin
      errors++;
      $display("FAIL stalled counts: got done=%0d cen_low=%0d expected 1 4", nd, nc);
    end
  endtask

  task automatic test_zero_len();
    int nd, ne, nc;
    run_seq("zero_len", 0, 1, 1, 32'h0, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 1 || nc != 0) begin
      errors++;
      $display("FAIL zero_len counts: got done=%0d cen_low=%0d expected 1 0", nd, nc);
    end
  endtask

  task automatic test_reset_mid_load();
    int nd, ne, nc;
    run_seq("abort", 5, 2, 0, 32'h0, -1, 2, nd, ne, nc);
    checks++;
    if (nd != 0 || nc != 2) begin
      errors++;
      $display("FAIL abort counts: got done=%0d cen_low=%0d expected 0 2", nd, nc);
    end
    run_seq("after_abort", 5, 3, 0, 32'h0, -1, -1, nd, ne, nc);
    checks++;
    if (nd != 1 || nc != 5) begin
      errors++;
      $display("FAIL after_abort counts: got done=%0d cen_low=%0d expected 1 5", nd, nc);
    end
  endtask

  task automatic test_start_while_busy();
    int nd, ne, nc;
    run_seq("busy_start_load", 3, 2, 0, 32'h0, 5, -1, nd, ne, nc);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL busy_start_load done count: got %0d expected 1", nd);
    end
    // start presented during the release cycle is also ignored (2+1+2+4+1 = 10)
    run_seq("busy_start_release", 2, 2, 0, 32'h0, 10, -1, nd, ne, nc);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL busy_start_release done count: got %0d expected 1", nd);
    end
  endtask

  task automatic test_random();
    int nd, ne, nc, len, ack, vm, bsc;
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(0, 6);
      ack = $urandom_range(1, 10);
      vm  = $urandom_range(0, 1);
      bsc = $urandom_range(1, 14);
      run_seq("random", len, ack, vm, 32'h0, bsc, -1, nd, ne, nc);
      checks++;
      if (ack > T ? (nd != 0 || ne != 1) : (nd != 1 || ne != 0 || nc != len)) begin
        errors++;
        $display("FAIL random[%0d] len=%0d ack=%0d: got done=%0d err=%0d cen_low=%0d",
                 i, len, ack, nd, ne, nc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_stalled();
    test_zero_len();
    test_reset_mid_load();
    test_start_while_busy();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reconf_sequencer.md
Name: reconf_sequencer

Overview:
- Sequences one partial-reconfiguration cycle of a reconfigurable region (RR).
- Handshakes with the RR to quiesce it, then drives is_reconfn low to isolate RR outputs.
- Streams the bitstream words into the configuration port, holds RR reset, then releases isolation.
- Sits beside the region's isolator, between the system control logic and the configuration port.

Parameters:
- LEN_W, 16: width of bitstream length (32-bit words).
- RST_CYCLES, 4: cycles rr_reset is held after load (>=1).
- ACK_TIMEOUT, 1024: max cycles to wait for rc_ackn before aborting (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin reconfiguration; sampled only in IDLE
- bs_len  in  LEN_W  number of words to load; captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on ack timeout
- rc_reqn  out  1  active-low unload request to RR
- rc_ackn  in  1  active-low RR acknowledge (via isolator)
- is_reconfn  out  1  active-low isolation enable to isolator
- rr_reset  out  1  active-high reset to RR
- bs_valid  in  1  bitstream word available
- bs_data  in  32  bitstream word
- bs_ready  out  1  sequencer accepts word
- icap_cen  out  1  active-low config-port enable, registered
- icap_data  out  32  config-port data, registered

Behaviour:
- Reset values: busy=0, done=0, err=0, rc_reqn=1, is_reconfn=1, rr_reset=0, bs_ready=0, icap_cen=1, icap_data=0; state=IDLE. Reset mid-operation aborts immediately to these values; no done/err pulse.
- All outputs registered except bs_ready, which is decoded from state (LOAD and remaining count != 0).
- States: IDLE, REQ, ISOLATE, LOAD, RESET, RELEASE.
- IDLE: start=1 captures bs_len into cnt and goes to REQ; rc_reqn=0 from the next cycle.
- REQ: rc_reqn=0; timer counts cycles in REQ.
  - rc_ackn==0 -> ISOLATE.
  - Timer reaches ACK_TIMEOUT-1 without ack -> err pulse, rc_reqn=1, go to IDLE. RR is never isolated.
  - Ack and timeout in the same cycle: ack wins.
- ISOLATE: is_reconfn=0, rc_reqn=1; one settle cycle. Next state is LOAD if cnt!=0, else RESET.
- LOAD: is_reconfn=0, bs_ready=1.
  - Each bs_valid&&bs_ready writes icap_data<=bs_data and icap_cen<=0 for exactly that next cycle, and decrements cnt.
  - cnt reaching 0 -> RESET. No bubbles inserted; back-to-back words sustain 1 word/cycle. bs_valid low -> icap_cen=1.
- RESET: is_reconfn=0, rr_reset=1 for exactly RST_CYCLES cycles, then RELEASE.
- RELEASE: rr_reset=0, is_reconfn=1 (registered); done pulses this cycle; next state IDLE.
- rc_ackn is ignored outside REQ; the isolator forces it high during isolation.
- start while busy: ignored, not queued.
- cnt is LEN_W bits, decrement only, no wrap. bs_len=0 -> no bs_ready, no icap_cen low.

Decomposition:
- Shared package xdrs_pkg: state encoding enum (reconf_state_t), default RST_CYCLES/ACK_TIMEOUT constants.
- No sub-module needed. Optionally, reconf_timer (shared down-counter for ack timeout and reset hold), instantiated once and loaded per state.

Test Plan:
- Nominal, start with bs_len=3, RR acks 2 cycles after rc_reqn=0, words streamed without gaps:
  - rc_reqn low 2 cycles.
  - is_reconfn low from ISOLATE through RESET.
  - icap_cen low exactly 3 consecutive cycles carrying the 3 words in order.
  - rr_reset high 4 cycles, then is_reconfn=1 with a single done pulse; busy drops the next cycle.
- Ack timeout, ACK_TIMEOUT=8, rc_ackn held 1 -> err pulse after 8 REQ cycles, rc_reqn returns 1, is_reconfn never 0, no done.
- Stalled source, bs_len=4, bs_valid toggling 1,0,0,1,1,0,1 -> icap_cen low only on cycles following accepted words, 4 total; completes normally.
- bs_len=0 -> ISOLATE goes straight to RESET; bs_ready never 1; done pulses.
- rst asserted during LOAD after 2 of 5 words -> next cycle all outputs at reset values (is_reconfn=1, rr_reset=0, icap_cen=1); a new start then runs a full sequence.
- start pulsed again while busy -> ignored; exactly one done per accepted start.
